// File: rtl/uart_rx_assembler.sv
// Packs four LSB-first bytes from uart_rx into a 32-bit word.
// Partial words are dropped on rx_err or inter-byte timeout.
module uart_rx_assembler #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_err,
  output logic [31:0] rx_float,
  output logic        rx_float_valid,
  output logic        timeout_err,
  output logic        frame_err,
  output logic [1:0]  byte_count
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_t                 state;
  logic [23:0]            buffer;
  logic [TIMEOUT_W-1:0]   counter;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      buffer         <= '0;
      counter        <= '0;
      byte_count     <= '0;
      rx_float       <= '0;
      rx_float_valid <= 1'b0;
      timeout_err    <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      rx_float_valid <= 1'b0;
      timeout_err    <= 1'b0;
      frame_err      <= 1'b0;

      if (rx_err) begin
        // error wins over both byte acceptance and completion
        state      <= IDLE;
        byte_count <= '0;
        counter    <= '0;
        frame_err  <= 1'b1;
      end else if (rx_valid) begin
        counter <= '0;
        if (state == COLLECT && byte_count == 2'd3) begin
          rx_float       <= {rx_data, buffer};
          rx_float_valid <= 1'b1;
          byte_count     <= '0;
          state          <= IDLE;
        end else begin
          unique case (byte_count)
            2'd0:    buffer[7:0]   <= rx_data;
            2'd1:    buffer[15:8]  <= rx_data;
            default: buffer[23:16] <= rx_data;
          endcase
          byte_count <= byte_count + 2'd1;
          state      <= COLLECT;
        end
      end else if (state == COLLECT && TO_EN) begin
        if (counter == TO_LAST) begin
          state       <= IDLE;
          byte_count  <= '0;
          counter     <= '0;
          timeout_err <= 1'b1;
        end else begin
          counter <= counter + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_assembler.sv
// Directed bench for uart_rx_assembler with a 16-cycle timeout.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_rx_assembler;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic [31:0] rx_float;
  logic        rx_float_valid;
  logic        timeout_err;
  logic        frame_err;
  logic [1:0]  byte_count;

  int checks;
  int failures;
  bit excl_bad;

  uart_rx_assembler #(
    .TIMEOUT_CYCLES(16),
    .TIMEOUT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_err(rx_err),
    .rx_float(rx_float),
    .rx_float_valid(rx_float_valid),
    .timeout_err(timeout_err),
    .frame_err(frame_err),
    .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (32'(rx_float_valid) + 32'(timeout_err) + 32'(frame_err) > 1)
      excl_bad = 1'b1;

  // apply inputs for one cycle, return at the next falling edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic e);
    rx_valid = v;
    rx_data  = d;
    rx_err   = e;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({rx_float, rx_float_valid, timeout_err, frame_err, byte_count} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs got float=%h v=%b to=%b fe=%b bc=%0d exp all 0",
               rx_float, rx_float_valid, timeout_err, frame_err, byte_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] b [4] = '{8'hDB, 8'h0F, 8'h49, 8'h40};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, b[i], 1'b0);
      checks++;
      if (byte_count !== 2'((i + 1) % 4)) begin
        failures++;
        $display("FAIL basic_count byte=%0d got=%0d exp=%0d", i, byte_count, (i + 1) % 4);
      end
      if (i < 3) begin
        checks++;
        if (rx_float_valid !== 1'b0) begin
          failures++;
          $display("FAIL basic_early_valid byte=%0d got=%b exp=0", i, rx_float_valid);
        end
        cyc(1'b0, 8'h00, 1'b0);
        repeat (8) cyc(1'b0, 8'h00, 1'b0);
      end
    end
    checks++;
    if (rx_float_valid !== 1'b1 || rx_float !== 32'h40490FDB) begin
      failures++;
      $display("FAIL basic_word got v=%b %h exp v=1 40490fdb", rx_float_valid, rx_float);
    end
    cyc(1'b0, 8'h00, 1'b0);
    checks++;
    if (rx_float_valid !== 1'b0 || rx_float !== 32'h40490FDB) begin
      failures++;
      $display("FAIL basic_hold got v=%b %h exp v=0 40490fdb", rx_float_valid, rx_float);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [8] = '{8'h00, 8'h00, 8'h80, 8'h3F, 8'h00, 8'h00, 8'h00, 8'hC0};
    int vcount = 0;
    int errs = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, b[i], 1'b0);
      if (rx_float_valid) vcount++;
      if (timeout_err || frame_err) errs++;
      if (i == 3) begin
        checks++;
        if (rx_float_valid !== 1'b1 || rx_float !== 32'h3F800000) begin
          failures++;
          $display("FAIL b2b_word0 got v=%b %h exp v=1 3f800000", rx_float_valid, rx_float);
        end
      end
      if (i == 7) begin
        checks++;
        if (rx_float_valid !== 1'b1 || rx_float !== 32'hC0000000) begin
          failures++;
          $display("FAIL b2b_word1 got v=%b %h exp v=1 c0000000", rx_float_valid, rx_float);
        end
      end
    end
    cyc(1'b0, 8'h00, 1'b0);
    checks++;
    if (vcount !== 2 || errs !== 0 || rx_float_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pulses got valids=%0d errs=%0d exp 2 0", vcount, errs);
    end
  endtask

  task automatic test_timeout;
    int to_at = -1;
    int to_n = 0;
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (timeout_err) begin
        to_n++;
        if (to_at < 0) to_at = k;
      end
      if (k == 15) begin
        checks++;
        if (byte_count !== 2'd2) begin
          failures++;
          $display("FAIL to_pending_count got=%0d exp=2", byte_count);
        end
      end
    end
    checks++;
    if (to_at !== 16 || to_n !== 1) begin
      failures++;
      $display("FAIL to_pulse got at=%0d n=%0d exp at=16 n=1", to_at, to_n);
    end
    checks++;
    if (byte_count !== 2'd0 || rx_float !== 32'hC0000000) begin
      failures++;
      $display("FAIL to_after got bc=%0d %h exp 0 c0000000", byte_count, rx_float);
    end
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    cyc(1'b1, 8'h04, 1'b0);
    checks++;
    if (rx_float_valid !== 1'b1 || rx_float !== 32'h04030201) begin
      failures++;
      $display("FAIL to_resync got v=%b %h exp v=1 04030201", rx_float_valid, rx_float);
    end
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_timeout_boundary;
    int seen = 0;
    cyc(1'b1, 8'h55, 1'b0);
    repeat (15) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (timeout_err) seen++;
    end
    cyc(1'b1, 8'h66, 1'b0);
    if (timeout_err) seen++;
    checks++;
    if (seen !== 0 || byte_count !== 2'd2) begin
      failures++;
      $display("FAIL tob_accept got to=%0d bc=%0d exp 0 2", seen, byte_count);
    end
    cyc(1'b1, 8'h77, 1'b0);
    cyc(1'b1, 8'h88, 1'b0);
    checks++;
    if (rx_float_valid !== 1'b1 || rx_float !== 32'h88776655) begin
      failures++;
      $display("FAIL tob_word got v=%b %h exp v=1 88776655", rx_float_valid, rx_float);
    end
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_frame_err;
    cyc(1'b1, 8'hAA, 1'b0);
    cyc(1'b1, 8'hBB, 1'b0);
    cyc(1'b1, 8'hCC, 1'b1);
    checks++;
    if (frame_err !== 1'b1 || rx_float_valid !== 1'b0 || byte_count !== 2'd0) begin
      failures++;
      $display("FAIL fe_pulse got fe=%b v=%b bc=%0d exp 1 0 0", frame_err, rx_float_valid, byte_count);
    end
    cyc(1'b1, 8'hEF, 1'b0);
    checks++;
    if (frame_err !== 1'b0 || byte_count !== 2'd1) begin
      failures++;
      $display("FAIL fe_clear got fe=%b bc=%0d exp 0 1", frame_err, byte_count);
    end
    cyc(1'b1, 8'hBE, 1'b0);
    cyc(1'b1, 8'hAD, 1'b0);
    cyc(1'b1, 8'hDE, 1'b0);
    checks++;
    if (rx_float_valid !== 1'b1 || rx_float !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL fe_resync got v=%b %h exp v=1 deadbeef", rx_float_valid, rx_float);
    end
    cyc(1'b1, 8'h10, 1'b0);
    cyc(1'b1, 8'h20, 1'b0);
    cyc(1'b1, 8'h30, 1'b0);
    cyc(1'b1, 8'h40, 1'b1);
    checks++;
    if (rx_float_valid !== 1'b0 || frame_err !== 1'b1 || rx_float !== 32'hDEADBEEF
        || byte_count !== 2'd0) begin
      failures++;
      $display("FAIL fe_fourth got v=%b fe=%b %h bc=%0d exp 0 1 deadbeef 0",
               rx_float_valid, frame_err, rx_float, byte_count);
    end
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [7:0] b [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
    cyc(1'b1, 8'h9A, 1'b0);
    cyc(1'b1, 8'hBC, 1'b0);
    cyc(1'b1, 8'hDE, 1'b0);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    rst      = 1'b1;
    #1;
    checks++;
    if ({rx_float, rx_float_valid, timeout_err, frame_err, byte_count} !== 37'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got float=%h v=%b to=%b fe=%b bc=%0d exp all 0",
               rx_float, rx_float_valid, timeout_err, frame_err, byte_count);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
    checks++;
    if ({rx_float_valid, timeout_err, frame_err, byte_count} !== 5'd0) begin
      failures++;
      $display("FAIL rstmid_release got v=%b to=%b fe=%b bc=%0d exp all 0",
               rx_float_valid, timeout_err, frame_err, byte_count);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, b[i], 1'b0);
    checks++;
    if (rx_float_valid !== 1'b1 || rx_float !== 32'h12345678) begin
      failures++;
      $display("FAIL rstmid_word got v=%b %h exp v=1 12345678", rx_float_valid, rx_float);
    end
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    excl_bad = 1'b0;
    clk      = 1'b0;
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_err   = 1'b0;

    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_timeout_boundary();
    test_frame_err();
    test_reset_mid();

    checks++;
    if (excl_bad !== 1'b0) begin
      failures++;
      $display("FAIL pulse_exclusive got=1 exp=0");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
